// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - shared types and constants for the CSR access unit
package csr_access_unit_pkg;

    localparam int DEFAULT_MXLEN  = 64;
    localparam int DEFAULT_ADDR_W = 12;

    // CSR addresses whose top two bits are 11 are read-only by construction
    localparam logic [1:0] CSR_READ_ONLY_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        NO_COMMAND     = 2'b00,
        READ_ONLY      = 2'b01,
        WRITE_ONLY     = 2'b10,
        WRITE_AND_READ = 2'b11
    } csr_command_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCESS    = 3'd1,
        RMW_READ  = 3'd2,
        RMW_WRITE = 3'd3,
        RESPOND   = 3'd4
    } csr_access_state_t;

    typedef enum logic [2:0] {
        FUNCT3_CSRRW  = 3'b001,
        FUNCT3_CSRRS  = 3'b010,
        FUNCT3_CSRRC  = 3'b011,
        FUNCT3_CSRRWI = 3'b101,
        FUNCT3_CSRRSI = 3'b110,
        FUNCT3_CSRRCI = 3'b111
    } csr_funct3_t;

    // True for the six Zicsr encodings; 000 and 100 are not CSR instructions
    function automatic logic funct3_supported(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            FUNCT3_CSRRW, FUNCT3_CSRRS, FUNCT3_CSRRC,
            FUNCT3_CSRRWI, FUNCT3_CSRRSI, FUNCT3_CSRRCI: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - sequences one Zicsr instruction into CSR file accesses
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int MXLEN  = DEFAULT_MXLEN,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_csr_address_i,
    input  logic [4:0]        req_rs1_index_i,
    input  logic [MXLEN-1:0]  req_rs1_data_i,
    input  logic [4:0]        req_rd_index_i,
    input  logic              kill_i,
    output logic [ADDR_W-1:0] csr_address_o,
    output csr_command_t      csr_command_o,
    output logic [MXLEN-1:0]  csr_write_data_o,
    input  logic [MXLEN-1:0]  csr_read_data_i,
    input  logic              csr_read_data_valid_i,
    output logic              resp_valid_o,
    output logic              resp_rd_write_o,
    output logic [4:0]        resp_rd_index_o,
    output logic [MXLEN-1:0]  resp_rd_data_o,
    output logic              resp_illegal_o
);

    csr_access_state_t state, state_next;

    logic [ADDR_W-1:0] address_q;
    logic [MXLEN-1:0]  operand_q;
    logic [MXLEN-1:0]  old_q;
    logic [4:0]        rd_q;
    logic              clear_q;
    logic              illegal_q;
    csr_command_t      command_q;

    logic [MXLEN-1:0]  operand;
    logic              mask_zero;
    logic              is_rw;
    logic              write_issuing;
    logic              ro_target;
    csr_command_t      accept_command;
    csr_access_state_t accept_state;
    logic              accept_illegal;
    logic [MXLEN-1:0]  rmw_data;

    // Decode the offered request: operand, mask, first state and single-access command
    always_comb begin
        operand        = req_funct3_i[2] ? {{(MXLEN-5){1'b0}}, req_rs1_index_i} : req_rs1_data_i;
        mask_zero      = (req_rs1_index_i == 5'd0);
        is_rw          = (req_funct3_i[1:0] == 2'b01);
        write_issuing  = is_rw || !mask_zero;
        ro_target      = (req_csr_address_i[ADDR_W-1 -: 2] == CSR_READ_ONLY_PREFIX);
        accept_command = READ_ONLY;
        accept_state   = ACCESS;
        accept_illegal = 1'b0;
        if (!funct3_supported(req_funct3_i) || (ro_target && write_issuing)) begin
            accept_command = NO_COMMAND;
            accept_state   = RESPOND;
            accept_illegal = 1'b1;
        end else if (is_rw) begin
            accept_command = (req_rd_index_i == 5'd0) ? WRITE_ONLY : WRITE_AND_READ;
        end else if (!mask_zero) begin
            accept_state   = RMW_READ;
        end
    end

    // Set/clear arithmetic for the write half of a read-modify-write
    always_comb begin
        rmw_data = clear_q ? (old_q & ~operand_q) : (old_q | operand_q);
    end

    // Next state and CSR-side command; kill and reset suppress the command immediately
    always_comb begin
        state_next       = state;
        csr_command_o    = NO_COMMAND;
        csr_write_data_o = '0;
        case (state)
            IDLE: begin
                if (req_valid_i) state_next = accept_state;
            end
            ACCESS: begin
                csr_command_o = command_q;
                if (command_q != READ_ONLY) csr_write_data_o = operand_q;
                state_next    = RESPOND;
            end
            RMW_READ: begin
                csr_command_o = READ_ONLY;
                state_next    = csr_read_data_valid_i ? RMW_WRITE : RESPOND;
            end
            RMW_WRITE: begin
                csr_command_o    = WRITE_ONLY;
                csr_write_data_o = rmw_data;
                state_next       = RESPOND;
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if ((kill_i && state != IDLE) || reset_i) begin
            state_next       = IDLE;
            csr_command_o    = NO_COMMAND;
            csr_write_data_o = '0;
        end
    end

    // State register plus request capture and access-result capture
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= IDLE;
            address_q <= '0;
            operand_q <= '0;
            old_q     <= '0;
            rd_q      <= '0;
            clear_q   <= 1'b0;
            illegal_q <= 1'b0;
            command_q <= NO_COMMAND;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        address_q <= req_csr_address_i;
                        operand_q <= operand;
                        rd_q      <= req_rd_index_i;
                        clear_q   <= (req_funct3_i[1:0] == 2'b11);
                        command_q <= accept_command;
                        illegal_q <= accept_illegal;
                        old_q     <= '0;
                    end
                end
                ACCESS, RMW_READ: begin
                    old_q     <= csr_read_data_i;
                    illegal_q <= !csr_read_data_valid_i;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake, address and response outputs derived from the current state
    always_comb begin
        req_ready_o     = (state == IDLE);
        csr_address_o   = (state != IDLE) ? address_q : '0;
        resp_valid_o    = (state == RESPOND) && !kill_i;
        resp_illegal_o  = resp_valid_o && illegal_q;
        resp_rd_write_o = resp_valid_o && !illegal_q && (rd_q != 5'd0);
        resp_rd_index_o = resp_valid_o ? rd_q : 5'd0;
        resp_rd_data_o  = (resp_valid_o && !illegal_q) ? old_q : '0;
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - self-checking bench for csr_access_unit
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_funct3 = '0;
    logic [11:0]  req_addr = '0;
    logic [4:0]   req_idx = '0;
    logic [63:0]  req_data = '0;
    logic [4:0]   req_rd = '0;
    logic         kill = 1'b0;
    logic [11:0]  csr_address;
    csr_command_t csr_command;
    logic [63:0]  csr_write_data;
    logic [63:0]  csr_read_data;
    logic         csr_read_valid;
    logic         resp_valid, resp_rd_write, resp_illegal;
    logic [4:0]   resp_rd_index;
    logic [63:0]  resp_rd_data;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] csr_mem [0:4095];
    logic [63:0] ref_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [63:0] pl_data = '0;

    csr_access_unit dut (
        .clock_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_funct3_i(req_funct3), .req_csr_address_i(req_addr),
        .req_rs1_index_i(req_idx), .req_rs1_data_i(req_data), .req_rd_index_i(req_rd),
        .kill_i(kill),
        .csr_address_o(csr_address), .csr_command_o(csr_command),
        .csr_write_data_o(csr_write_data), .csr_read_data_i(csr_read_data),
        .csr_read_data_valid_i(csr_read_valid),
        .resp_valid_o(resp_valid), .resp_rd_write_o(resp_rd_write),
        .resp_rd_index_o(resp_rd_index), .resp_rd_data_o(resp_rd_data),
        .resp_illegal_o(resp_illegal)
    );

    always #5 clk = ~clk;

    function automatic bit csr_exists(input logic [11:0] a);
        case (a)
            12'h340, 12'h341, 12'h304, 12'h305, 12'hF14, 12'hC00: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // CSR file model: combinational read, write committed at the clock edge
    always_comb begin
        csr_read_valid = csr_exists(csr_address);
        csr_read_data  = csr_read_valid ? csr_mem[csr_address] : 64'd0;
    end

    always @(posedge clk) begin
        if (pl_en)
            csr_mem[pl_addr] <= pl_data;
        else if ((csr_command == WRITE_ONLY || csr_command == WRITE_AND_READ) && csr_exists(csr_address))
            csr_mem[csr_address] <= csr_write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Reference: what the CSR file should see and what writeback should get
    task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                         input logic [63:0] d, input logic [4:0] rd,
                         output logic ill, output logic rdw, output logic [63:0] rdd,
                         output int ncmd, output logic [7:0] cmds);
        logic [63:0] op, old;
        bit ex, ro, rw, wr;
        op   = f3[2] ? {59'd0, idx} : d;
        ex   = csr_exists(a);
        ro   = (a[11:10] == 2'b11);
        rw   = (f3[1:0] == 2'b01);
        wr   = rw || (idx != 5'd0);
        old  = ex ? ref_mem[a] : 64'd0;
        ill  = 1'b0; ncmd = 0; cmds = '0;
        if (f3[1:0] == 2'b00 || (ro && wr)) begin
            ill = 1'b1;
        end else if (rw) begin
            ncmd = 1;
            cmds[1:0] = (rd == 5'd0) ? WRITE_ONLY : WRITE_AND_READ;
            ill = !ex;
            if (ex) ref_mem[a] = op;
        end else if (idx == 5'd0 || !ex) begin
            ncmd = 1;
            cmds[1:0] = READ_ONLY;
            ill = !ex;
        end else begin
            ncmd = 2;
            cmds[1:0] = READ_ONLY;
            cmds[3:2] = WRITE_ONLY;
            ref_mem[a] = (f3[1:0] == 2'b11) ? (old & ~op) : (old | op);
        end
        rdd = ill ? 64'd0 : old;
        rdw = (rd != 5'd0) && !ill;
    endtask

    task automatic run_instr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                             input logic [63:0] d, input logic [4:0] rd, input bit kill_acc,
                             output bit got, output int lat, output logic ill, output logic rdw,
                             output logic [4:0] rdi, output logic [63:0] rdd,
                             output int ncmd, output logic [7:0] cmds);
        got = 1'b0; lat = 0; ill = 1'b0; rdw = 1'b0; rdi = '0; rdd = '0; ncmd = 0; cmds = '0;
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_idx = idx; req_data = d; req_rd = rd;
        kill = kill_acc;
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; lat = i + 1;
                ill = resp_illegal; rdw = resp_rd_write; rdi = resp_rd_index; rdd = resp_rd_data;
            end else if (csr_command != NO_COMMAND) begin
                if (ncmd < 4) cmds[2*ncmd +: 2] = csr_command;
                ncmd++;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [63:0] init;
        logic        ill;
        logic        rdw;
        logic [63:0] rdd;
        int          ncmd;
        logic [1:0]  cmd0;
        logic [63:0] fin;
    } vec_t;

    vec_t tbl [13];

    task automatic check_result(input string tag, input logic [11:0] a, input logic [4:0] rd,
                                input bit got, input int lat, input logic ill, input logic rdw,
                                input logic [4:0] rdi, input logic [63:0] rdd, input int ncmd,
                                input logic [7:0] cmds, input logic e_ill, input logic e_rdw,
                                input logic [63:0] e_rdd, input int e_ncmd, input logic [7:0] e_cmds,
                                input logic [63:0] e_fin);
        chk({tag, " resp_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, " latency"}, 64'(lat), 64'(e_ncmd + 1));
            chk({tag, " illegal"}, 64'(ill), 64'(e_ill));
            chk({tag, " rd_write"}, 64'(rdw), 64'(e_rdw));
            chk({tag, " rd_index"}, 64'(rdi), 64'(rd));
            if (!e_ill) chk({tag, " rd_data"}, rdd, e_rdd);
        end
        chk({tag, " n_commands"}, 64'(ncmd), 64'(e_ncmd));
        chk({tag, " commands"}, 64'(cmds), 64'(e_cmds));
        if (csr_exists(a)) chk({tag, " csr_value"}, csr_mem[a], e_fin);
    endtask

    initial begin
        bit got; int lat; logic ill, rdw; logic [4:0] rdi; logic [63:0] rdd; int ncmd; logic [7:0] cmds;
        logic e_ill, e_rdw; logic [63:0] e_rdd; int e_ncmd; logic [7:0] e_cmds;
        logic [11:0] addr_pool [8];
        int resp_count;

        addr_pool = '{12'h340, 12'h341, 12'h304, 12'h305, 12'hF14, 12'hC00, 12'h7C0, 12'hFC0};

        //        f3      addr     idx    data                   rd     init     ill  rdw  rdd      ncmd cmd0            fin
        tbl[0]  = '{3'b001, 12'h340, 5'd1, 64'hDEAD_BEEF,        5'd5,  64'h1234, 0, 1, 64'h1234, 1, WRITE_AND_READ, 64'hDEAD_BEEF};
        tbl[1]  = '{3'b010, 12'h304, 5'd2, 64'h888,              5'd3,  64'h0,    0, 1, 64'h0,    2, READ_ONLY,      64'h888};
        tbl[2]  = '{3'b111, 12'h304, 5'd0, 64'h0,                5'd0,  64'h888,  0, 0, 64'h888,  1, READ_ONLY,      64'h888};
        tbl[3]  = '{3'b001, 12'hF14, 5'd1, 64'h5,                5'd1,  64'h0,    1, 0, 64'h0,    0, NO_COMMAND,     64'h0};
        tbl[4]  = '{3'b010, 12'h7C0, 5'd4, 64'h1,                5'd2,  64'h0,    1, 0, 64'h0,    1, READ_ONLY,      64'h0};
        tbl[5]  = '{3'b101, 12'h340, 5'd31, 64'h0,               5'd0,  64'h7,    0, 0, 64'h7,    1, WRITE_ONLY,     64'h1F};
        tbl[6]  = '{3'b110, 12'h340, 5'd16, 64'h0,               5'd8,  64'h0F,   0, 1, 64'h0F,   2, READ_ONLY,      64'h1F};
        tbl[7]  = '{3'b011, 12'h340, 5'd9, 64'h0F,               5'd4,  64'hFF,   0, 1, 64'hFF,   2, READ_ONLY,      64'hF0};
        tbl[8]  = '{3'b000, 12'h340, 5'd3, 64'h1,                5'd7,  64'h55,   1, 0, 64'h0,    0, NO_COMMAND,     64'h55};
        tbl[9]  = '{3'b100, 12'h304, 5'd3, 64'h1,                5'd7,  64'h66,   1, 0, 64'h0,    0, NO_COMMAND,     64'h66};
        tbl[10] = '{3'b010, 12'hF14, 5'd0, 64'h0,                5'd6,  64'hABC,  0, 1, 64'hABC,  1, READ_ONLY,      64'hABC};
        tbl[11] = '{3'b010, 12'hC00, 5'd3, 64'h0,                5'd6,  64'h77,   1, 0, 64'h0,    0, NO_COMMAND,     64'h77};
        tbl[12] = '{3'b001, 12'h7C0, 5'd2, 64'h9,                5'd1,  64'h0,    1, 0, 64'h0,    1, WRITE_AND_READ, 64'h0};

        for (int i = 0; i < 4096; i++) ref_mem[i] = 64'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset command", 64'(csr_command), 64'(NO_COMMAND));
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 64'(req_ready), 64'd1);
        chk("reset address", 64'(csr_address), 64'd0);
        chk("reset write_data", csr_write_data, 64'd0);
        chk("reset resp_fields", 64'({resp_rd_write, resp_illegal, resp_rd_index}), 64'd0);
        chk("reset rd_data", resp_rd_data, 64'd0);

        for (int a = 0; a < 8; a++) preload(addr_pool[a], 64'd0);

        // directed vector table
        for (int v = 0; v < 13; v++) begin
            preload(tbl[v].addr, tbl[v].init);
            chk($sformatf("vec%0d ready", v), 64'(req_ready), 64'd1);
            run_instr(tbl[v].f3, tbl[v].addr, tbl[v].idx, tbl[v].data, tbl[v].rd, 1'b0,
                      got, lat, ill, rdw, rdi, rdd, ncmd, cmds);
            chk($sformatf("vec%0d resp_seen", v), 64'(got), 64'd1);
            if (got) begin
                chk($sformatf("vec%0d latency", v), 64'(lat), 64'(tbl[v].ncmd + 1));
                chk($sformatf("vec%0d illegal", v), 64'(ill), 64'(tbl[v].ill));
                chk($sformatf("vec%0d rd_write", v), 64'(rdw), 64'(tbl[v].rdw));
                if (!tbl[v].ill) chk($sformatf("vec%0d rd_data", v), rdd, tbl[v].rdd);
            end
            chk($sformatf("vec%0d n_commands", v), 64'(ncmd), 64'(tbl[v].ncmd));
            chk($sformatf("vec%0d first_command", v), 64'(cmds[1:0]), 64'(tbl[v].cmd0));
            if (csr_exists(tbl[v].addr)) chk($sformatf("vec%0d csr_value", v), csr_mem[tbl[v].addr], tbl[v].fin);
            ref_mem[tbl[v].addr] = tbl[v].fin;
        end

        // kill during RMW_WRITE of CSRRC on mscratch
        preload(12'h340, 64'hFF);
        req_valid = 1'b1; req_funct3 = 3'b011; req_addr = 12'h340; req_idx = 5'd9; req_data = 64'h0F; req_rd = 5'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("kill_rmw read_cmd", 64'(csr_command), 64'(READ_ONLY));
        @(posedge clk); #1;
        kill = 1'b1; #1;
        chk("kill_rmw command", 64'(csr_command), 64'(NO_COMMAND));
        chk("kill_rmw resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_rmw ready", 64'(req_ready), 64'd1);
        resp_count = 0;
        repeat (3) begin @(negedge clk); if (resp_valid) resp_count++; end
        chk("kill_rmw no_resp", 64'(resp_count), 64'd0);
        chk("kill_rmw csr_value", csr_mem[12'h340], 64'hFF);
        @(posedge clk); #1;

        // kill during ACCESS of CSRRW
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_idx = 5'd1; req_data = 64'h1111; req_rd = 5'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        kill = 1'b1; #1;
        chk("kill_access command", 64'(csr_command), 64'(NO_COMMAND));
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_access ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("kill_access resp_valid", 64'(resp_valid), 64'd0);
        chk("kill_access csr_value", csr_mem[12'h340], 64'hFF);
        @(posedge clk); #1;

        // reset pulsed during RMW_READ
        preload(12'h304, 64'h10);
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 12'h304; req_idx = 5'd2; req_data = 64'h1; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1; #1;
        chk("reset_mid command_now", 64'(csr_command), 64'(NO_COMMAND));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_mid command", 64'(csr_command), 64'(NO_COMMAND));
        chk("reset_mid resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_mid ready", 64'(req_ready), 64'd1);
        resp_count = 0;
        repeat (3) begin @(negedge clk); if (resp_valid) resp_count++; end
        chk("reset_mid no_resp", 64'(resp_count), 64'd0);
        chk("reset_mid csr_value", csr_mem[12'h304], 64'h10);
        @(posedge clk); #1;

        // randomized instructions against the reference model
        for (int a = 0; a < 6; a++) preload(addr_pool[a], {$urandom, $urandom});
        for (int n = 0; n < 150; n++) begin
            logic [2:0] f3; logic [11:0] a; logic [4:0] idx, rd; logic [63:0] d; bit ka;
            f3  = 3'($urandom_range(0, 7));
            a   = addr_pool[$urandom_range(0, 7)];
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d   = {$urandom, $urandom};
            ka  = ($urandom_range(0, 7) == 0);
            model(f3, a, idx, d, rd, e_ill, e_rdw, e_rdd, e_ncmd, e_cmds);
            run_instr(f3, a, idx, d, rd, ka, got, lat, ill, rdw, rdi, rdd, ncmd, cmds);
            check_result($sformatf("rand%0d f3=%0d a=%0h", n, f3, a), a, rd, got, lat, ill, rdw, rdi, rdd,
                         ncmd, cmds, e_ill, e_rdw, e_rdd, e_ncmd, e_cmds, ref_mem[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
